// File: rtl/pic_pkg.sv
// Shared types and register bit positions for the 8259 PIC bus front end.
// Imported by pic_bus_interface.
package pic_pkg;

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } pic_bus_state_t;

    localparam int ICW1_ID_BIT  = 4;
    localparam int SNGL_BIT     = 1;
    localparam int IC4_BIT      = 0;
    localparam int OCW3_SEL_BIT = 3;

endpackage

// File: rtl/pic_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous, active-low CPU strobe.
// Resets to 1 (strobe inactive); output follows the input after SYNC_STAGES edges.
module pic_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pic_bus_interface.sv
// 8259 PIC bus front end: synchronises CS_/RD_/WR_, commits writes on WR_ rising edge,
// runs the ICW1..ICW4 sequence and decodes OCW1..OCW3. Optional: PIC_BUS_CONFLICT_DETECT_EN.
module pic_bus_interface
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CS_,
    input  logic                  RD_,
    input  logic                  WR_,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D_in,
    output logic                  rd_en,
    output logic                  wr_strobe,
    output logic [ADDR_WIDTH-1:0] A_out,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  icw1_wr,
    output logic                  icw2_wr,
    output logic                  icw3_wr,
    output logic                  icw4_wr,
    output logic                  ocw1_wr,
    output logic                  ocw2_wr,
    output logic                  ocw3_wr,
    output logic                  init_done
`ifdef PIC_BUS_CONFLICT_DETECT_EN
    ,
    output logic                  bus_conflict
`endif
);

    logic cs_s, rd_s, wr_s;
    logic cs_s_prev, wr_s_prev;
    logic [SYNC_STAGES+1:0] settle_q;
    logic settled;
    logic wr_rise;
    logic commit;
    logic is_icw1;

    pic_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk  (clk),
        .reset(reset),
        .din  (CS_),
        .dout (cs_s)
    );

    pic_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
        .clk  (clk),
        .reset(reset),
        .din  (RD_),
        .dout (rd_s)
    );

    pic_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
        .clk  (clk),
        .reset(reset),
        .din  (WR_),
        .dout (wr_s)
    );

    // Commits are blanked until the synchronisers hold real pin values, so a write
    // that straddled reset cannot masquerade as a fresh WR_ rising edge.
    assign settled = settle_q[SYNC_STAGES+1];
    assign wr_rise = !wr_s_prev && wr_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_s_prev <= 1'b1;
            wr_s_prev <= 1'b1;
            settle_q  <= '0;
            rd_en     <= 1'b0;
            A_out     <= '0;
            wdata     <= '0;
        end else begin
            cs_s_prev <= cs_s;
            wr_s_prev <= wr_s;
            settle_q  <= {settle_q[SYNC_STAGES:0], 1'b1};
            rd_en     <= !cs_s && !rd_s && wr_s;
            if (!cs_s && !wr_s) begin
                A_out <= A;
                wdata <= D_in;
            end
        end
    end

`ifdef PIC_BUS_CONFLICT_DETECT_EN
    logic conflict_now;
    logic wr_tainted;

    assign conflict_now = !cs_s && !rd_s && !wr_s;

    // A write that overlapped a read at any point is dropped when WR_ rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_tainted   <= 1'b0;
            bus_conflict <= 1'b0;
        end else begin
            if (wr_rise) begin
                wr_tainted <= 1'b0;
            end else if (conflict_now) begin
                wr_tainted <= 1'b1;
            end
            if (conflict_now) begin
                bus_conflict <= 1'b1;
            end else if (commit && is_icw1) begin
                bus_conflict <= 1'b0;
            end
        end
    end

    assign commit = settled && wr_rise && !cs_s_prev && !wr_tainted;
`else
    assign commit = settled && wr_rise && !cs_s_prev;
`endif

    assign is_icw1 = !A_out[0] && wdata[ICW1_ID_BIT];

    pic_bus_state_t state, state_nxt;
    logic sngl, sngl_nxt;
    logic ic4, ic4_nxt;
    logic icw1_nxt, icw2_nxt, icw3_nxt, icw4_nxt;
    logic ocw1_nxt, ocw2_nxt, ocw3_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= UNINIT;
            sngl      <= 1'b0;
            ic4       <= 1'b0;
            wr_strobe <= 1'b0;
            icw1_wr   <= 1'b0;
            icw2_wr   <= 1'b0;
            icw3_wr   <= 1'b0;
            icw4_wr   <= 1'b0;
            ocw1_wr   <= 1'b0;
            ocw2_wr   <= 1'b0;
            ocw3_wr   <= 1'b0;
        end else begin
            state     <= state_nxt;
            sngl      <= sngl_nxt;
            ic4       <= ic4_nxt;
            wr_strobe <= commit;
            icw1_wr   <= icw1_nxt;
            icw2_wr   <= icw2_nxt;
            icw3_wr   <= icw3_nxt;
            icw4_wr   <= icw4_nxt;
            ocw1_wr   <= ocw1_nxt;
            ocw2_wr   <= ocw2_nxt;
            ocw3_wr   <= ocw3_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sngl_nxt  = sngl;
        ic4_nxt   = ic4;
        icw1_nxt  = 1'b0;
        icw2_nxt  = 1'b0;
        icw3_nxt  = 1'b0;
        icw4_nxt  = 1'b0;
        ocw1_nxt  = 1'b0;
        ocw2_nxt  = 1'b0;
        ocw3_nxt  = 1'b0;
        if (commit) begin
            if (is_icw1) begin
                state_nxt = WAIT_ICW2;
                icw1_nxt  = 1'b1;
                sngl_nxt  = wdata[SNGL_BIT];
                ic4_nxt   = wdata[IC4_BIT];
            end else begin
                unique case (state)
                    WAIT_ICW2: begin
                        if (A_out[0]) begin
                            icw2_nxt = 1'b1;
                            if (!sngl) begin
                                state_nxt = WAIT_ICW3;
                            end else if (ic4) begin
                                state_nxt = WAIT_ICW4;
                            end else begin
                                state_nxt = READY;
                            end
                        end
                    end
                    WAIT_ICW3: begin
                        if (A_out[0]) begin
                            icw3_nxt  = 1'b1;
                            state_nxt = ic4 ? WAIT_ICW4 : READY;
                        end
                    end
                    WAIT_ICW4: begin
                        if (A_out[0]) begin
                            icw4_nxt  = 1'b1;
                            state_nxt = READY;
                        end
                    end
                    READY: begin
                        // ICW1 already claimed D[4]=1, so with A0=0 only D[3] selects.
                        if (A_out[0]) begin
                            ocw1_nxt = 1'b1;
                        end else if (!wdata[OCW3_SEL_BIT]) begin
                            ocw2_nxt = 1'b1;
                        end else begin
                            ocw3_nxt = 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = state;
                    end
                endcase
            end
        end
    end

    assign init_done = (state == READY);

endmodule

// File: tb/tb_pic_bus_interface.sv
// Scoreboard bench for pic_bus_interface: directed writes push expected strobes,
// a negedge monitor pops and checks them.
module tb_pic_bus_interface;

    localparam int S = 2;

    localparam logic [6:0] P_NONE = 7'b0000000;
    localparam logic [6:0] P_ICW1 = 7'b1000000;
    localparam logic [6:0] P_ICW2 = 7'b0100000;
    localparam logic [6:0] P_ICW3 = 7'b0010000;
    localparam logic [6:0] P_ICW4 = 7'b0001000;
    localparam logic [6:0] P_OCW1 = 7'b0000100;
    localparam logic [6:0] P_OCW2 = 7'b0000010;
    localparam logic [6:0] P_OCW3 = 7'b0000001;

    typedef struct {
        int         cyc;
        logic [6:0] pulses;
        logic [7:0] wdata;
        logic       a0;
        logic       init;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs_pin = 1'b1;
    logic       rd_pin = 1'b1;
    logic       wr_pin = 1'b1;
    logic [0:0] a_pin = '0;
    logic [7:0] d_pin = '0;

    logic       rd_en, wr_strobe, init_done;
    logic [0:0] a_out;
    logic [7:0] wdata;
    logic       icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr;
`ifdef PIC_BUS_CONFLICT_DETECT_EN
    logic       bus_conflict;
`endif

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    pic_bus_interface #(.SYNC_STAGES(S), .DATA_WIDTH(8), .ADDR_WIDTH(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .CS_         (cs_pin),
        .RD_         (rd_pin),
        .WR_         (wr_pin),
        .A           (a_pin),
        .D_in        (d_pin),
        .rd_en       (rd_en),
        .wr_strobe   (wr_strobe),
        .A_out       (a_out),
        .wdata       (wdata),
        .icw1_wr     (icw1_wr),
        .icw2_wr     (icw2_wr),
        .icw3_wr     (icw3_wr),
        .icw4_wr     (icw4_wr),
        .ocw1_wr     (ocw1_wr),
        .ocw2_wr     (ocw2_wr),
        .ocw3_wr     (ocw3_wr),
        .init_done   (init_done)
`ifdef PIC_BUS_CONFLICT_DETECT_EN
        ,
        .bus_conflict(bus_conflict)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    wire [6:0] pulses = {icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr};

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_strobe) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", {25'd0, pulses}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("pulses", {25'd0, pulses}, {25'd0, e.pulses});
                    chk("wdata", {24'd0, wdata}, {24'd0, e.wdata});
                    chk("a_out", {31'd0, a_out}, {31'd0, e.a0});
                    chk("init_done_at_strobe", {31'd0, init_done}, {31'd0, e.init});
                end
            end else if (pulses != P_NONE) begin
                chk("pulse_without_strobe", {25'd0, pulses}, 32'd0);
            end
        end
    end

    // One CPU write; CS_ rises together with WR_.
    task automatic do_write(input logic a0, input logic [7:0] dat, input logic [6:0] p,
                            input logic init, input bit cs_low, input bit expect_commit);
        exp_t e;
        @(posedge clk); #1;
        cs_pin = !cs_low;
        a_pin  = a0;
        d_pin  = dat;
        wr_pin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wr_pin = 1'b1;
        cs_pin = 1'b1;
        if (expect_commit) begin
            e.cyc    = cyc + S + 1;
            e.pulses = p;
            e.wdata  = dat;
            e.a0     = a0;
            e.init   = init;
            q.push_back(e);
        end
        repeat (S + 4) @(posedge clk);
        #1;
        chk("strobe_seen", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_pulses", pulses, 0);
`ifdef PIC_BUS_CONFLICT_DETECT_EN
        chk("rst_bus_conflict", bus_conflict, 0);
`endif
        repeat (S + 4) @(posedge clk);

        // Uninitialised: non-ICW1 write strobes without decode.
        do_write(1'b0, 8'h20, P_NONE, 1'b0, 1'b1, 1'b1);

        // rd_en latency
        @(posedge clk); #1;
        cs_pin = 1'b0;
        rd_pin = 1'b0;
        repeat (S) @(posedge clk);
        @(negedge clk);
        chk("rd_en_early", rd_en, 0);
        @(negedge clk);
        chk("rd_en_level", rd_en, 1);
        @(posedge clk); #1;
        cs_pin = 1'b1;
        rd_pin = 1'b1;
        repeat (S + 3) @(posedge clk);
        @(negedge clk);
        chk("rd_en_release", rd_en, 0);

        // Test 1: single mode with ICW4
        do_write(1'b0, 8'h13, P_ICW1, 1'b0, 1'b1, 1'b1);
        do_write(1'b1, 8'h20, P_ICW2, 1'b0, 1'b1, 1'b1);
        do_write(1'b1, 8'h01, P_ICW4, 1'b1, 1'b1, 1'b1);
        chk("t1_init_done", init_done, 1);

        // Test 2: cascade mode, all four ICWs, then OCW1
        do_write(1'b0, 8'h11, P_ICW1, 1'b0, 1'b1, 1'b1);
        chk("t2_init_cleared", init_done, 0);
        do_write(1'b1, 8'h08, P_ICW2, 1'b0, 1'b1, 1'b1);
        do_write(1'b1, 8'h04, P_ICW3, 1'b0, 1'b1, 1'b1);
        do_write(1'b1, 8'h01, P_ICW4, 1'b1, 1'b1, 1'b1);
        do_write(1'b1, 8'hFF, P_OCW1, 1'b1, 1'b1, 1'b1);

        // Test 3: READY decode
        do_write(1'b0, 8'h20, P_OCW2, 1'b1, 1'b1, 1'b1);
        do_write(1'b0, 8'h0B, P_OCW3, 1'b1, 1'b1, 1'b1);
        do_write(1'b1, 8'hFE, P_OCW1, 1'b1, 1'b1, 1'b1);

        // Test 4: CS_ high ignores read and write
        @(posedge clk); #1;
        rd_pin = 1'b0;
        for (int i = 0; i < S + 3; i++) begin
            @(negedge clk);
            chk("t4_rd_en", rd_en, 0);
        end
        @(posedge clk); #1;
        rd_pin = 1'b1;
        do_write(1'b0, 8'h13, P_NONE, 1'b1, 1'b0, 1'b0);
        chk("t4_state_kept", init_done, 1);
        do_write(1'b1, 8'h5A, P_OCW1, 1'b1, 1'b1, 1'b1);

        // Test 5: reset in the middle of an ICW3 write
        do_write(1'b0, 8'h11, P_ICW1, 1'b0, 1'b1, 1'b1);
        do_write(1'b1, 8'h08, P_ICW2, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        cs_pin = 1'b0;
        a_pin  = 1'b1;
        d_pin  = 8'h04;
        wr_pin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        wr_pin = 1'b1;
        cs_pin = 1'b1;
        repeat (S + 5) @(posedge clk);
        @(negedge clk);
        chk("t5_init_done", init_done, 0);
        do_write(1'b0, 8'h20, P_NONE, 1'b0, 1'b1, 1'b1);

        // Test 6: RD_ and WR_ low together
        do_write(1'b0, 8'h13, P_ICW1, 1'b0, 1'b1, 1'b1);
        do_write(1'b1, 8'h20, P_ICW2, 1'b0, 1'b1, 1'b1);
        do_write(1'b1, 8'h01, P_ICW4, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        cs_pin = 1'b0;
        rd_pin = 1'b0;
        wr_pin = 1'b0;
        a_pin  = 1'b1;
        d_pin  = 8'h55;
        for (int i = 0; i < S + 3; i++) begin
            @(negedge clk);
            chk("t6_rd_en", rd_en, 0);
        end
        @(posedge clk); #1;
        wr_pin = 1'b1;
        rd_pin = 1'b1;
        cs_pin = 1'b1;
        k = cyc;
`ifndef PIC_BUS_CONFLICT_DETECT_EN
        q.push_back('{cyc: k + S + 1, pulses: P_OCW1, wdata: 8'h55, a0: 1'b1, init: 1'b1});
`endif
        repeat (S + 4) @(posedge clk);
        #1;
        chk("t6_strobe_seen", q.size(), 0);
        q.delete();
`ifdef PIC_BUS_CONFLICT_DETECT_EN
        chk("t6_bus_conflict", bus_conflict, 1);
        do_write(1'b0, 8'h13, P_ICW1, 1'b0, 1'b1, 1'b1);
        chk("t6_conflict_cleared", bus_conflict, 0);
`endif

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
